// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory stage: funct3 access sizes, LSU handshake states
// and the MEM/WB pipeline register layout.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        MS_B  = 3'b000,
        MS_H  = 3'b001,
        MS_W  = 3'b010,
        MS_BU = 3'b100,
        MS_HU = 3'b101
    } memSize;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } lsuState;

    typedef struct packed {
        logic        valid;
        logic        rdWriteEn;
        logic        misalignedExc;
        logic [4:0]  rdAddr;
        logic [31:0] rdWriteData;
        logic [31:0] pc;
    } wbReg;

    // Byte accesses are always aligned; halfwords need bit 0 clear, words both bits.
    function automatic logic isAligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            MS_H, MS_HU: isAligned = ~off[0];
            MS_W:        isAligned = (off == 2'b00);
            default:     isAligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data formatting: shifts the addressed byte/halfword down and extends it.
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] value
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            MS_B:    value = {{24{shifted[7]}}, shifted[7:0]};
            MS_H:    value = {{16{shifted[15]}}, shifted[15:0]};
            MS_BU:   value = {24'h000000, shifted[7:0]};
            MS_HU:   value = {16'h0000, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the rv32imc pipeline: data-memory req/gnt/rvalid handshake,
// load alignment, upstream stall generation and the MEM/WB register.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    input  logic            inMemRead,
    input  logic            inMemWrite,
    input  logic [2:0]      inSize,
    input  logic [XLEN-1:0] inAddr,
    input  logic [XLEN-1:0] inStoreData,
    input  logic [4:0]      inRdAddr,
    input  logic            inRdWriteEn,
    input  logic [XLEN-1:0] inRdWriteData,
    input  logic [XLEN-1:0] inPc,
    output logic            dmemReq,
    output logic            dmemWe,
    output logic [XLEN-1:0] dmemAddr,
    output logic [3:0]      dmemBe,
    output logic [XLEN-1:0] dmemWdata,
    input  logic            dmemGnt,
    input  logic            dmemRvalid,
    input  logic [XLEN-1:0] dmemRdata,
    output logic            stall,
    output logic            outValid,
    output logic            outRdWriteEn,
    output logic            misalignedExc,
    output logic [4:0]      outRdAddr,
    output logic [XLEN-1:0] outRdWriteData,
    output logic [XLEN-1:0] outPc
);

    lsuState         state, stateNext;
    wbReg            wb, wbNext;

    logic [XLEN-1:0] latAddr, latStoreData, latPc;
    logic [2:0]      latSize;
    logic            latStore, latRdWriteEn;
    logic [4:0]      latRdAddr;

    logic            memOp, aligned, accept;
    logic            reqStore;
    logic [XLEN-1:0] reqAddr, reqData;
    logic [2:0]      reqSize;
    logic [31:0]     loadValue;

    assign memOp   = inValid & (inMemRead | inMemWrite);
    assign aligned = isAligned(inSize, inAddr[1:0]);
    assign accept  = (state == IDLE) & memOp & aligned & ~rst;

    load_align u_align (
        .rdata  (dmemRdata),
        .offset (latAddr[1:0]),
        .size   (latSize),
        .value  (loadValue)
    );

    // In IDLE the request is issued straight from EX/MEM; afterwards from the latched copy.
    always_comb begin
        if (state == IDLE) begin
            reqStore = inMemWrite;
            reqAddr  = inAddr;
            reqData  = inStoreData;
            reqSize  = inSize;
        end else begin
            reqStore = latStore;
            reqAddr  = latAddr;
            reqData  = latStoreData;
            reqSize  = latSize;
        end
    end

    always_comb begin
        stateNext = state;
        dmemReq   = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (memOp && aligned) begin
                    dmemReq = 1'b1;
                    if (!dmemGnt) begin
                        stateNext = REQ;
                        stall     = 1'b1;
                    end else if (!inMemWrite) begin
                        stateNext = WAIT_R;
                        stall     = 1'b1;
                    end
                end
            end
            REQ: begin
                dmemReq = 1'b1;
                if (!dmemGnt) begin
                    stall = 1'b1;
                end else if (latStore) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = WAIT_R;
                    stall     = 1'b1;
                end
            end
            WAIT_R: begin
                if (dmemRvalid) stateNext = IDLE;
                else            stall     = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
        if (rst) begin
            stateNext = IDLE;
            dmemReq   = 1'b0;
            stall     = 1'b0;
        end
    end

    always_comb begin
        dmemWe    = dmemReq & reqStore;
        dmemAddr  = '0;
        dmemBe    = '0;
        dmemWdata = '0;
        if (dmemReq) begin
            dmemAddr = {reqAddr[XLEN-1:2], 2'b00};
            case (reqSize[1:0])
                2'b00: begin
                    dmemBe    = 4'b0001 << reqAddr[1:0];
                    dmemWdata = {4{reqData[7:0]}};
                end
                2'b01: begin
                    dmemBe    = 4'b0011 << {reqAddr[1], 1'b0};
                    dmemWdata = {2{reqData[15:0]}};
                end
                default: begin
                    dmemBe    = 4'b1111;
                    dmemWdata = reqData;
                end
            endcase
        end
    end

    // An unstalled REQ/WAIT_R cycle is always the completing access of the latched instruction.
    always_comb begin
        wbNext = '0;
        if (!stall) begin
            case (state)
                WAIT_R: begin
                    wbNext.valid       = 1'b1;
                    wbNext.rdWriteEn   = latRdWriteEn;
                    wbNext.rdAddr      = latRdAddr;
                    wbNext.rdWriteData = loadValue;
                    wbNext.pc          = latPc;
                end
                REQ: begin
                    wbNext.valid       = 1'b1;
                    wbNext.rdWriteEn   = latRdWriteEn;
                    wbNext.rdAddr      = latRdAddr;
                    wbNext.rdWriteData = inRdWriteData;
                    wbNext.pc          = latPc;
                end
                default: begin
                    if (inValid) begin
                        wbNext.valid         = 1'b1;
                        wbNext.misalignedExc = memOp & ~aligned;
                        wbNext.rdWriteEn     = inRdWriteEn & ~(memOp & ~aligned);
                        wbNext.rdAddr        = inRdAddr;
                        wbNext.rdWriteData   = inRdWriteData;
                        wbNext.pc            = inPc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb           <= '0;
            latAddr      <= '0;
            latStoreData <= '0;
            latPc        <= '0;
            latSize      <= '0;
            latStore     <= 1'b0;
            latRdWriteEn <= 1'b0;
            latRdAddr    <= '0;
        end else begin
            state <= stateNext;
            wb    <= wbNext;
            if (accept) begin
                latAddr      <= inAddr;
                latStoreData <= inStoreData;
                latPc        <= inPc;
                latSize      <= inSize;
                latStore     <= inMemWrite;
                latRdWriteEn <= inRdWriteEn;
                latRdAddr    <= inRdAddr;
            end
        end
    end

    assign outValid       = wb.valid;
    assign outRdWriteEn   = wb.rdWriteEn;
    assign misalignedExc  = wb.misalignedExc;
    assign outRdAddr      = wb.rdAddr;
    assign outRdWriteData = wb.rdWriteData;
    assign outPc          = wb.pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table driven through a
// latency-configurable memory responder, MEM/WB results checked via a scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0, inMemRead = 1'b0, inMemWrite = 1'b0;
    logic [2:0]  inSize = '0;
    logic [31:0] inAddr = '0, inStoreData = '0, inRdWriteData = '0, inPc = '0;
    logic [4:0]  inRdAddr = '0;
    logic        inRdWriteEn = 1'b0;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWdata;
    logic [3:0]  dmemBe;
    logic        dmemGnt = 1'b0, dmemRvalid = 1'b0;
    logic [31:0] dmemRdata = '0;
    logic        stall, outValid, outRdWriteEn, misalignedExc;
    logic [4:0]  outRdAddr;
    logic [31:0] outRdWriteData, outPc;

    mem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inSize(inSize), .inAddr(inAddr), .inStoreData(inStoreData), .inRdAddr(inRdAddr),
        .inRdWriteEn(inRdWriteEn), .inRdWriteData(inRdWriteData), .inPc(inPc),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemBe(dmemBe),
        .dmemWdata(dmemWdata), .dmemGnt(dmemGnt), .dmemRvalid(dmemRvalid), .dmemRdata(dmemRdata),
        .stall(stall), .outValid(outValid), .outRdWriteEn(outRdWriteEn),
        .misalignedExc(misalignedExc), .outRdAddr(outRdAddr), .outRdWriteData(outRdWriteData),
        .outPc(outPc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Memory responder: grants after gntDelay request cycles, returns load data rvDelay cycles after the grant cycle's successor.
    int          gntDelay = 0, rvDelay = 0, gntCnt = 0, rvCnt = 0;
    logic        rvPending = 1'b0;
    logic [31:0] memRdata = '0;

    always @(negedge clk) begin
        dmemGnt    = 1'b0;
        dmemRvalid = 1'b0;
        if (rvPending) begin
            if (rvCnt == 0) begin
                dmemRvalid = 1'b1;
                dmemRdata  = memRdata;
                rvPending  = 1'b0;
            end else begin
                rvCnt--;
            end
        end else if (dmemReq) begin
            if (gntCnt >= gntDelay) begin
                dmemGnt = 1'b1;
                gntCnt  = 0;
                if (!dmemWe) begin
                    rvPending = 1'b1;
                    rvCnt     = rvDelay;
                end
            end else begin
                gntCnt++;
            end
        end
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (outValid) begin
            if (sb.size() == 0) begin
                chk("spurious_outValid", {31'd0, outValid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_rdAddr", {27'd0, outRdAddr}, {27'd0, e.rd});
                chk("out_rdWriteEn", {31'd0, outRdWriteEn}, {31'd0, e.we});
                chk("out_misalignedExc", {31'd0, misalignedExc}, {31'd0, e.exc});
                chk("out_rdWriteData", outRdWriteData, e.data);
                chk("out_pc", outPc, e.pc);
            end
        end
    end

    typedef struct {
        string       name;
        logic        rd, wr;
        logic [2:0]  size;
        logic [31:0] addr, sdata;
        logic [4:0]  rdA;
        logic        rdWe;
        logic [31:0] rdData, pc, rdata;
        int          gd, rvd;
        logic [31:0] expData;
        logic        expWe, expExc;
        int          expStall;
        logic        expReq;
        logic [31:0] expMAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic rd, input logic wr, input logic [2:0] sz,
                                input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdA,
                                input logic rdWe, input logic [31:0] rdData, input logic [31:0] rdata,
                                input int gd, input int rvd, input logic [31:0] ed, input logic ewe,
                                input logic eexc, input int est, input logic ereq, input logic [31:0] ema,
                                input logic [3:0] ebe, input logic [31:0] ewd);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.size = sz; v.addr = addr; v.sdata = sdata;
        v.rdA = rdA; v.rdWe = rdWe; v.rdData = rdData; v.pc = '0; v.rdata = rdata;
        v.gd = gd; v.rvd = rvd; v.expData = ed; v.expWe = ewe; v.expExc = eexc;
        v.expStall = est; v.expReq = ereq; v.expMAddr = ema; v.expBe = ebe; v.expWdata = ewd;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        int          st;
        logic        sawReq, gotGnt, gWe, done;
        logic [31:0] gAddr, gWdata;
        logic [3:0]  gBe;
        exp_t        e;
        @(posedge clk); #1;
        inValid = 1'b1; inMemRead = v.rd; inMemWrite = v.wr; inSize = v.size;
        inAddr = v.addr; inStoreData = v.sdata; inRdAddr = v.rdA; inRdWriteEn = v.rdWe;
        inRdWriteData = v.rdData; inPc = v.pc;
        gntDelay = v.gd; rvDelay = v.rvd; memRdata = v.rdata;
        e.rd = v.rdA; e.we = v.expWe; e.exc = v.expExc; e.data = v.expData; e.pc = v.pc;
        sb.push_back(e);
        st = 0; sawReq = 1'b0; gotGnt = 1'b0; gWe = 1'b0; done = 1'b0;
        gAddr = '0; gWdata = '0; gBe = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (dmemReq) sawReq = 1'b1;
            if (dmemReq && dmemGnt) begin
                gotGnt = 1'b1; gAddr = dmemAddr; gBe = dmemBe; gWdata = dmemWdata; gWe = dmemWe;
            end
            if (!stall) begin
                done = 1'b1;
                break;
            end
            st++;
        end
        chk({v.name, "_completed"}, {31'd0, done}, 32'd1);
        chk({v.name, "_stall_cycles"}, st, v.expStall);
        chk({v.name, "_dmemReq_seen"}, {31'd0, sawReq}, {31'd0, v.expReq});
        if (v.expReq) begin
            chk({v.name, "_granted"}, {31'd0, gotGnt}, 32'd1);
            chk({v.name, "_dmemAddr"}, gAddr, v.expMAddr);
            chk({v.name, "_dmemWe"}, {31'd0, gWe}, {31'd0, v.wr});
            if (v.wr) begin
                chk({v.name, "_dmemBe"}, {28'd0, gBe}, {28'd0, v.expBe});
                chk({v.name, "_dmemWdata"}, gWdata, v.expWdata);
            end
        end
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("lb",      1, 0, 3'b000, 32'h1003, 32'h0,        5'd1, 1, 32'h1003, 32'h80FFFFFF, 0, 0,
                       32'hFFFFFF80, 1, 0, 1, 1, 32'h1000, 4'h0, 32'h0);
        vecs[1]  = mk("lbu",     1, 0, 3'b100, 32'h1003, 32'h0,        5'd2, 1, 32'h1003, 32'h80FFFFFF, 0, 0,
                       32'h00000080, 1, 0, 1, 1, 32'h1000, 4'h0, 32'h0);
        vecs[2]  = mk("sh",      0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd0, 0, 32'h2002, 32'h0,        0, 0,
                       32'h2002,     0, 0, 0, 1, 32'h2000, 4'b1100, 32'hABCDABCD);
        vecs[3]  = mk("lw_wait", 1, 0, 3'b010, 32'h3000, 32'h0,        5'd3, 1, 32'h3000, 32'hDEADBEEF, 2, 1,
                       32'hDEADBEEF, 1, 0, 4, 1, 32'h3000, 4'h0, 32'h0);
        vecs[4]  = mk("lw_mis",  1, 0, 3'b010, 32'h3002, 32'h0,        5'd4, 1, 32'h3002, 32'h0,        0, 0,
                       32'h3002,     0, 1, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[5]  = mk("alu",     0, 0, 3'b010, 32'h42,   32'h0,        5'd5, 1, 32'h42,   32'h0,        0, 0,
                       32'h42,       1, 0, 0, 0, 32'h0,    4'h0, 32'h0);
        vecs[6]  = mk("lhu",     1, 0, 3'b101, 32'h4002, 32'h0,        5'd6, 1, 32'h4002, 32'hBEEF0000, 0, 0,
                       32'h0000BEEF, 1, 0, 1, 1, 32'h4000, 4'h0, 32'h0);
        vecs[7]  = mk("sb_gw",   0, 1, 3'b000, 32'h5001, 32'h000000A5, 5'd0, 0, 32'h5001, 32'h0,        1, 0,
                       32'h5001,     0, 0, 1, 1, 32'h5000, 4'b0010, 32'hA5A5A5A5);
        vecs[8]  = mk("lh_rw",   1, 0, 3'b001, 32'h6002, 32'h0,        5'd7, 1, 32'h6002, 32'h80010000, 0, 2,
                       32'hFFFF8001, 1, 0, 3, 1, 32'h6000, 4'h0, 32'h0);
        vecs[9]  = mk("sw",      0, 1, 3'b010, 32'h7000, 32'hCAFEF00D, 5'd0, 0, 32'h7000, 32'h0,        0, 0,
                       32'h7000,     0, 0, 0, 1, 32'h7000, 4'b1111, 32'hCAFEF00D);
        vecs[10] = mk("lb_pos",  1, 0, 3'b000, 32'h8000, 32'h0,        5'd8, 1, 32'h8000, 32'h0000007F, 0, 0,
                       32'h0000007F, 1, 0, 1, 1, 32'h8000, 4'h0, 32'h0);
        vecs[11] = mk("lhu_mis", 1, 0, 3'b101, 32'h8001, 32'h0,        5'd9, 1, 32'h8001, 32'h0,        0, 0,
                       32'h8001,     0, 1, 0, 0, 32'h0,    4'h0, 32'h0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("reset_outValid", {31'd0, outValid}, 32'd0);
        chk("reset_outRdWriteEn", {31'd0, outRdWriteEn}, 32'd0);
        chk("reset_misalignedExc", {31'd0, misalignedExc}, 32'd0);
        chk("reset_outRdWriteData", outRdWriteData, 32'd0);
        chk("reset_outPc", outPc, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_dmemReq", {31'd0, dmemReq}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            vecs[i].pc = 32'h100 + 32'(i * 4);
            apply(vecs[i]);
        end

        // Reset while a load waits for rvalid; its late rvalid must be dropped.
        @(posedge clk); #1;
        inValid = 1'b1; inMemRead = 1'b1; inMemWrite = 1'b0; inSize = 3'b010;
        inAddr = 32'h9000; inRdAddr = 5'd10; inRdWriteEn = 1'b1; inPc = 32'h200;
        gntDelay = 0; rvDelay = 4; memRdata = 32'h11111111;
        @(posedge clk); #1;
        rst = 1'b1; inValid = 1'b0; inMemRead = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_dmemReq", {31'd0, dmemReq}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_post_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_post_outRdWriteEn", {31'd0, outRdWriteEn}, 32'd0);
        chk("rst_post_outRdWriteData", outRdWriteData, 32'd0);
        chk("rst_post_stall", {31'd0, stall}, 32'd0);
        repeat (6) @(posedge clk);

        vecs[0].pc = 32'h300;
        apply(vecs[0]);

        @(posedge clk); #1;
        inValid = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
